ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage directly upstream of `icache`: holds the fetch PC, issues one-at-a-time pipelined lookups on the `icache` request port, discards responses made stale by redirects, and buffers returned instructions with their PCs in a small FIFO for the decode stage. Sustains one instruction per cycle on cache hits.

## Interface
- `DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `RESET_PC`, 16'h0000: fetch PC after reset.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `mem_req` out 1: to `icache`; fetch stage alive. Reset 0; 1 from the first edge after reset release.
- `mem_ppl_submit` out 1: one-cycle submit of `mem_addr`. Reset 0.
- `mem_addr` out 16 (`RW`): instruction word address; equals fetch PC. Reset `RESET_PC`.
- `mem_cache_flush` out 1: one-cycle invalidate pulse to `icache`. Reset 0.
- `mem_ack` in 1: response valid, same cycle as `mem_data`.
- `mem_data` in 32 (`I_SIZE`): instruction word.
- `o_valid` out 1: FIFO head valid. Reset 0.
- `o_instr` out 32, `o_pc` out 16: FIFO head. Reset 0.
- `i_ready` in 1: decode takes head when `o_valid & i_ready`.
- `i_redirect` in 1: branch/exception redirect to `i_redirect_pc`.
- `i_redirect_pc` in 16.
- `i_cache_flush` in 1: invalidate request; only legal together with `i_redirect`.

## Operation
- Registers: `fetch_pc`, `out_pend` (one request in flight), `out_pc`, `drop` (in-flight response is stale), FIFO with `count`.
- `mem_addr` = `fetch_pc` combinationally; word addressed, PC +1 per instruction, wraps 16'hFFFF → 16'h0000.
- Credit: `live = count + (out_pend & ~drop) - (o_valid & i_ready)`.
- Submit (`mem_ppl_submit`=1) iff `mem_req & ~i_redirect & (~out_pend | mem_ack) & live < DEPTH`. On submit: `out_pend`←1, `out_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+1.
- `mem_ack` with `out_pend & ~drop & ~i_redirect`: push {`mem_data`, `out_pc`}. Ack with `drop`: discard, `drop`←0. Ack without submit same cycle: `out_pend`←0.
- Redirect: FIFO emptied (`count`←0, `o_valid`←0 next cycle), `fetch_pc`←`i_redirect_pc`, no submit that cycle. If `out_pend & ~mem_ack`: `drop`←1; if `mem_ack` same cycle, data discarded, `drop` stays 0.
- New submits after redirect wait until the dropped response acks (single outstanding rule).
- `i_cache_flush` (with redirect): `mem_cache_flush`←1 for exactly the next cycle. `icache` itself suppresses the line fill of an in-flight miss; ifetch still drops its ack.
- Simultaneous push and pop on non-empty FIFO: `count` unchanged. Push never occurs with FIFO full (credit guarantees); assertion required.
- Redirect while `i_ready` pops: pop ignored, FIFO cleared.
- Async reset mid-operation: all state to reset values immediately; in-flight response forgotten (`icache` reset together).

## Timing
- Hit: submit at cycle T, `mem_ack` at T+1, entry visible on `o_valid` at T+2.
- Back-to-back hits: submit every cycle while credit allows; steady 1 instr/cycle with `i_ready`=1.
- Miss: `mem_ack` arrives at end of 8-beat line fill; ifetch holds, no timeout.
- Redirect at cycle R: first new submit at R+1 if nothing in flight (or acked at R), else cycle after stale ack.
- `mem_cache_flush` asserted at R+1 only.
- First submit after reset release: second clock edge (`mem_req` rises first).

## Structure
- `RW`, `I_SIZE` from shared `config.v`; add `RESET_PC` default there.
- Sub-module `ifetch_fifo`: DEPTH×48-bit sync FIFO, registered head, push/pop/clear, `count` output, async reset.
- Top holds PC, in-flight/drop tracking, flush pulse.

## Test plan
- Reset, all hits, `i_ready`=1 → `mem_addr` 0,1,2,…; `o_pc`/`o_instr` match model from T+2, one per cycle.
- `i_ready`=0 → exactly 4 entries, `mem_ppl_submit` stops; `i_ready`=1 resumes without loss or duplication.
- Miss on 0x0010 (ack 9 cycles late), redirect to 0x0200 at cycle 3 → stale ack dropped, first `o_pc`=0x0200.
- Redirect in same cycle as `mem_ack` → that data not pushed, `drop` stays 0, next submit 0x0200 at R+1.
- `i_redirect`+`i_cache_flush` → `mem_cache_flush` high one cycle at R+1, FIFO empty, fetch restarts at `i_redirect_pc`.
- `fetch_pc` 0xFFFE, run 3 instructions → `o_pc` 0xFFFE, 0xFFFF, 0x0000; async reset mid-miss → outputs reset immediately, restart at `RESET_PC`.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared widths, reset PC default and the FIFO entry layout for the fetch stage.
package ifetch_pkg;
  localparam int RW     = 16;
  localparam int I_SIZE = 32;
  localparam logic [RW-1:0] RESET_PC_DFLT = 16'h0000;

  typedef struct packed {
    logic [I_SIZE-1:0] instr;
    logic [RW-1:0]     pc;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of {instr, pc} entries feeding decode.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [PW:0]  o_count
);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Clear wins over both push and pop.
  assign w_push = i_push & ~i_clear;
  assign w_pop  = i_pop & (r_count != '0) & ~i_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  // Upstream credit accounting must never push into a full FIFO without a pop.
  assert property (@(posedge i_clk) disable iff (i_rst)
    w_push |-> ((r_count != FULL) || w_pop));
endmodule

// File: rtl/ifetch.sv
// Fetch stage: owns the fetch PC, keeps one icache lookup in flight, drops
// responses made stale by redirects and buffers fetched words for decode.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter logic [RW-1:0] RESET_PC = RESET_PC_DFLT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              mem_req,
  output logic              mem_ppl_submit,
  output logic [RW-1:0]     mem_addr,
  output logic              mem_cache_flush,
  input  logic              mem_ack,
  input  logic [I_SIZE-1:0] mem_data,
  output logic              o_valid,
  output logic [I_SIZE-1:0] o_instr,
  output logic [RW-1:0]     o_pc,
  input  logic              i_ready,
  input  logic              i_redirect,
  input  logic [RW-1:0]     i_redirect_pc,
  input  logic              i_cache_flush
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] LIVE_MAX = (PW+2)'(DEPTH);

  logic          r_req;
  logic [RW-1:0] r_fetch_pc;
  logic          r_out_pend;
  logic [RW-1:0] r_out_pc;
  logic          r_drop;
  logic          r_flush;

  logic          w_pop;
  logic          w_push;
  logic          w_submit;
  logic [PW:0]   w_count;
  logic [PW+1:0] w_live;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  assign w_pop = o_valid & i_ready;

  // Entries that will occupy the FIFO: buffered plus a live in-flight lookup.
  assign w_live = {1'b0, w_count} + (PW+2)'(r_out_pend & ~r_drop) - (PW+2)'(w_pop);

  assign w_submit = r_req & ~i_redirect & (~r_out_pend | mem_ack) & (w_live < LIVE_MAX);
  assign w_push   = mem_ack & r_out_pend & ~r_drop & ~i_redirect;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_out_pend <= 1'b0;
      r_out_pc   <= RESET_PC;
      r_drop     <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_req   <= 1'b1;
      r_flush <= i_redirect & i_cache_flush;

      if (i_redirect)    r_fetch_pc <= i_redirect_pc;
      else if (w_submit) r_fetch_pc <= r_fetch_pc + 1'b1;

      if (w_submit) begin
        r_out_pend <= 1'b1;
        r_out_pc   <= r_fetch_pc;
      end else if (mem_ack) begin
        r_out_pend <= 1'b0;
      end

      // A response acked in the redirect cycle is simply not pushed.
      if (i_redirect & r_out_pend & ~mem_ack) r_drop <= 1'b1;
      else if (mem_ack)                       r_drop <= 1'b0;
    end
  end

  assign w_entry = '{instr: mem_data, pc: r_out_pc};

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_redirect),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_valid (o_valid),
    .o_count (w_count)
  );

  assign mem_req         = r_req;
  assign mem_ppl_submit  = w_submit;
  assign mem_addr        = r_fetch_pc;
  assign mem_cache_flush = r_flush;
  assign o_instr         = w_head.instr;
  assign o_pc            = w_head.pc;
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: icache responder, queue-based reference model, directed
// scenarios with literal expectations, then a randomized run.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_ppl_submit, mem_cache_flush;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [15:0] o_pc;
  logic        i_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_pc = '0;
  logic        i_cache_flush = 1'b0;

  ifetch #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .mem_req         (mem_req),
    .mem_ppl_submit  (mem_ppl_submit),
    .mem_addr        (mem_addr),
    .mem_cache_flush (mem_cache_flush),
    .mem_ack         (mem_ack),
    .mem_data        (mem_data),
    .o_valid         (o_valid),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
    .i_ready         (i_ready),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .i_cache_flush   (i_cache_flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fdata(input logic [15:0] a);
    return {~a, a ^ 16'h5A3C};
  endfunction

  // icache responder
  logic        ic_pend = 1'b0;
  int          ic_left = 0;
  logic [15:0] ic_addr = '0;
  logic        miss_en = 1'b0;
  logic [15:0] miss_addr = '0;
  logic        rand_lat = 1'b0;

  function automatic int pick_lat(input logic [15:0] a);
    if (miss_en && a == miss_addr) return 9;
    if (rand_lat) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : 1;
    return 1;
  endfunction

  // Reference model: queue of PCs that decode must see, plus fetch bookkeeping.
  logic [15:0] q[$];
  logic [15:0] pop_log[$];
  logic        m_req = 1'b0, m_out = 1'b0, m_stale = 1'b0, m_flush = 1'b0;
  logic [15:0] m_pc = '0, m_out_pc = '0;
  int          n_sub = 0;
  logic        c_valid, c_pop, c_sub;
  int          c_live;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_req = 0; m_out = 0; m_stale = 0; m_flush = 0;
      m_pc = 16'h0000; m_out_pc = 16'h0000;
      chk("rst_mem_req", 48'(mem_req), 48'd0);
      chk("rst_submit", 48'(mem_ppl_submit), 48'd0);
      chk("rst_mem_addr", 48'(mem_addr), 48'd0);
      chk("rst_flush", 48'(mem_cache_flush), 48'd0);
      chk("rst_o_valid", 48'(o_valid), 48'd0);
      chk("rst_o_head", {o_instr, o_pc}, 48'd0);
    end else begin
      c_valid = (q.size() != 0);
      chk("o_valid", 48'(o_valid), 48'(c_valid));
      if (c_valid) begin
        chk("o_pc", 48'(o_pc), 48'(q[0]));
        chk("o_instr", 48'(o_instr), 48'(fdata(q[0])));
      end
      chk("mem_req", 48'(mem_req), 48'(m_req));
      chk("mem_addr", 48'(mem_addr), 48'(m_pc));
      chk("mem_cache_flush", 48'(mem_cache_flush), 48'(m_flush));
      c_pop  = c_valid && i_ready;
      c_live = q.size() + ((m_out && !m_stale) ? 1 : 0) - (c_pop ? 1 : 0);
      c_sub  = m_req && !i_redirect && (!m_out || mem_ack) && (c_live < DEPTH);
      chk("mem_ppl_submit", 48'(mem_ppl_submit), 48'(c_sub));

      if (o_valid && i_ready && !i_redirect) pop_log.push_back(o_pc);
      if (mem_ppl_submit) n_sub++;

      if (mem_ack) ic_pend = 0;
      if (mem_ppl_submit) begin
        ic_pend = 1;
        ic_addr = mem_addr;
        ic_left = pick_lat(mem_addr);
      end

      if (i_redirect) q.delete();
      else begin
        if (c_pop) void'(q.pop_front());
        if (mem_ack && m_out && !m_stale) q.push_back(m_out_pc);
      end
      if (i_redirect && m_out && !mem_ack) m_stale = 1;
      else if (mem_ack)                    m_stale = 0;
      if (c_sub) begin
        m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 16'd1;
      end else if (mem_ack) m_out = 0;
      if (i_redirect) m_pc = i_redirect_pc;
      m_flush = i_redirect && i_cache_flush;
      m_req = 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    i_redirect = 0;
    i_cache_flush = 0;
    mem_data = $urandom;
    if (rst || !ic_pend) mem_ack = 0;
    else if (ic_left <= 1) begin
      mem_ack = 1;
      mem_data = fdata(ic_addr);
    end else begin
      mem_ack = 0;
      ic_left--;
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic redirect(input logic [15:0] pc, input logic flush);
    i_redirect = 1;
    i_redirect_pc = pc;
    i_cache_flush = flush;
  endtask

  logic found;
  int   n0;

  initial begin
    #1 rst = 1;
    i_ready = 1;
    run(3);
    settle();
    chk("reset_mem_addr", 48'(mem_addr), 48'h0000);
    chk("reset_o_valid", 48'(o_valid), 48'd0);
    tick(); rst = 0;
    settle();
    chk("rel_mem_req", 48'(mem_req), 48'd0);
    chk("rel_submit", 48'(mem_ppl_submit), 48'd0);
    tick(); settle();
    chk("first_req", 48'(mem_req), 48'd1);
    chk("first_submit", 48'(mem_ppl_submit), 48'd1);
    chk("first_addr", 48'(mem_addr), 48'h0000);

    // All hits, decode always ready.
    pop_log.delete();
    run(20);
    chk("hit_count", 48'(pop_log.size() >= 8), 48'd1);
    for (int i = 0; i < 8 && i < pop_log.size(); i++)
      chk("hit_seq", 48'(pop_log[i]), 48'(i));
    n0 = n_sub;
    run(10);
    chk("hit_rate", 48'(n_sub - n0), 48'd10);

    // Decode stalls: FIFO fills to DEPTH and fetch holds.
    i_ready = 0;
    run(12);
    settle();
    chk("full_submit", 48'(mem_ppl_submit), 48'd0);
    chk("full_valid", 48'(o_valid), 48'd1);
    chk("full_entries", 48'(q.size()), 48'd4);
    tick(); i_ready = 1;
    pop_log.delete();
    run(12);
    chk("resume_count", 48'(pop_log.size() >= 9), 48'd1);
    for (int i = 0; i < 8 && i + 1 < pop_log.size(); i++)
      chk("resume_seq", 48'(pop_log[i+1]), 48'(pop_log[i] + 16'd1));

    // Miss on 0x0010, redirect three cycles into it.
    miss_en = 1; miss_addr = 16'h0010;
    tick(); redirect(16'h0010, 1'b0);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); settle();
      if (mem_ppl_submit && mem_addr == 16'h0010) begin
        found = 1;
        break;
      end
    end
    chk("miss_sub_seen", 48'(found), 48'd1);
    run(2);
    tick(); redirect(16'h0200, 1'b0);
    pop_log.delete();
    run(20);
    miss_en = 0;
    chk("miss_pops", 48'(pop_log.size() > 0), 48'd1);
    if (pop_log.size() > 0) chk("miss_first_pc", 48'(pop_log[0]), 48'h0200);

    // Redirect in the same cycle as an ack.
    run(5);
    tick(); redirect(16'h0200, 1'b0);
    settle();
    chk("rack_ack", 48'(mem_ack), 48'd1);
    tick(); settle();
    chk("rack_submit", 48'(mem_ppl_submit), 48'd1);
    chk("rack_addr", 48'(mem_addr), 48'h0200);
    chk("rack_valid", 48'(o_valid), 48'd0);

    // Redirect with cache flush.
    run(5);
    tick(); redirect(16'h0400, 1'b1);
    settle();
    chk("flush_r0", 48'(mem_cache_flush), 48'd0);
    tick(); settle();
    chk("flush_r1", 48'(mem_cache_flush), 48'd1);
    chk("flush_valid", 48'(o_valid), 48'd0);
    chk("flush_submit", 48'(mem_ppl_submit), 48'd1);
    chk("flush_addr", 48'(mem_addr), 48'h0400);
    tick(); settle();
    chk("flush_r2", 48'(mem_cache_flush), 48'd0);

    // PC wrap.
    run(5);
    tick(); redirect(16'hFFFE, 1'b0);
    pop_log.delete();
    run(10);
    chk("wrap_count", 48'(pop_log.size() >= 3), 48'd1);
    if (pop_log.size() >= 3) begin
      chk("wrap0", 48'(pop_log[0]), 48'hFFFE);
      chk("wrap1", 48'(pop_log[1]), 48'hFFFF);
      chk("wrap2", 48'(pop_log[2]), 48'h0000);
    end

    // Async reset in the middle of a miss.
    miss_en = 1; miss_addr = 16'h0123;
    tick(); redirect(16'h0123, 1'b0);
    run(4);
    @(posedge clk); #3;
    rst = 1; ic_pend = 0; mem_ack = 0;
    #1;
    chk("arst_req", 48'(mem_req), 48'd0);
    chk("arst_valid", 48'(o_valid), 48'd0);
    chk("arst_addr", 48'(mem_addr), 48'h0000);
    chk("arst_submit", 48'(mem_ppl_submit), 48'd0);
    run(2);
    tick(); rst = 0;
    miss_en = 0;
    settle();
    chk("arst_hold", 48'(mem_ppl_submit), 48'd0);
    tick(); settle();
    chk("arst_restart", 48'(mem_ppl_submit), 48'd1);
    chk("arst_restart_addr", 48'(mem_addr), 48'h0000);

    // Randomized traffic with mixed latencies.
    rand_lat = 1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0)
        redirect(($urandom_range(0, 3) == 0) ? 16'(16'hFFFA + $urandom_range(0, 5)) : 16'($urandom),
                 ($urandom_range(0, 2) == 0));
    end
    tick(); settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
